// File: rtl/riscv_core_rob_pkg.sv
// Shared types for the multi-lane reorder buffer: entry layout, FSM states
// and the circular age helper.
package riscv_core_rob_pkg;

  localparam int AGE_W = 8;
  localparam int NREGS = 32;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic       we;
    logic [4:0] preg;
  } rob_entry_t;

  typedef enum logic {RUN, REBUILD} rob_state_e;

  // Distance from head; the caller truncates to its slot width, which gives mod DEPTH.
  function automatic logic [AGE_W-1:0] rob_age(input logic [AGE_W-1:0] slot,
                                               input logic [AGE_W-1:0] head);
    return slot - head;
  endfunction

endpackage

// File: rtl/riscv_core_rename_table.sv
// Architectural-register -> ROB-slot map with same-group bypass on lookup,
// allocate/commit/rebuild writes and a single-cycle clear.
module riscv_core_rename_table
  import riscv_core_rob_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SLOT_W = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH*10-1:0]       src_reg,
  output logic [WIDTH*2-1:0]        src_renamed,
  output logic [WIDTH*2*SLOT_W-1:0] src_slot,
  input  logic                      alloc_fire,
  input  logic [WIDTH-1:0]          alloc_wr,
  input  logic [WIDTH*5-1:0]        alloc_preg,
  input  logic [WIDTH*SLOT_W-1:0]   alloc_slot,
  input  logic [WIDTH-1:0]          cmt_clr,
  input  logic [WIDTH*5-1:0]        cmt_preg,
  input  logic [WIDTH*SLOT_W-1:0]   cmt_slot,
  input  logic                      clr_all,
  input  logic                      rb_we,
  input  logic [4:0]                rb_preg,
  input  logic [SLOT_W-1:0]         rb_slot
);

  logic [NREGS-1:0]                 ren_q, ren_d;
  logic [NREGS-1:0][SLOT_W-1:0]     slot_q, slot_d;
  logic [WIDTH*2-1:0][4:0]          sreg;
  logic [WIDTH*2-1:0][SLOT_W-1:0]   sslot;
  logic [WIDTH-1:0][4:0]            apreg, cpreg;
  logic [WIDTH-1:0][SLOT_W-1:0]     aslot, cslot;

  assign sreg     = src_reg;
  assign apreg    = alloc_preg;
  assign aslot    = alloc_slot;
  assign cpreg    = cmt_preg;
  assign cslot    = cmt_slot;
  assign src_slot = sslot;

  // Ascending lane scan so the youngest earlier lane overrides the table.
  always_comb begin
    src_renamed = '0;
    sslot       = '0;
    for (int s = 0; s < WIDTH*2; s++) begin
      src_renamed[s] = ren_q[sreg[s]] && (sreg[s] != 5'd0);
      sslot[s]       = slot_q[sreg[s]];
      for (int l = 0; l < s/2; l++) begin
        if (alloc_wr[l] && (apreg[l] == sreg[s])) begin
          src_renamed[s] = 1'b1;
          sslot[s]       = aslot[l];
        end
      end
    end
  end

  always_comb begin
    ren_d  = ren_q;
    slot_d = slot_q;
    for (int k = 0; k < WIDTH; k++)
      if (cmt_clr[k] && (slot_q[cpreg[k]] == cslot[k])) ren_d[cpreg[k]] = 1'b0;
    // Allocation is applied after commit so a same-cycle rename keeps its mapping.
    if (alloc_fire) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (alloc_wr[k]) begin
          ren_d[apreg[k]]  = 1'b1;
          slot_d[apreg[k]] = aslot[k];
        end
      end
    end
    if (rb_we) begin
      ren_d[rb_preg]  = 1'b1;
      slot_d[rb_preg] = rb_slot;
    end
    if (clr_all) ren_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ren_q  <= '0;
      slot_q <= '0;
    end else begin
      ren_q  <= ren_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/riscv_core_rob_multi.sv
// WIDTH-lane reorder buffer: in-order allocate/commit, out-of-order done,
// precise squash with a head-to-tail walk that rebuilds the rename table.
module riscv_core_rob_multi
  import riscv_core_rob_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 2,
  parameter int SLOT_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          alloc_req,
  input  logic [WIDTH-1:0]          alloc_we,
  input  logic [WIDTH*5-1:0]        alloc_preg,
  output logic                      alloc_ready,
  output logic [WIDTH*SLOT_W-1:0]   alloc_slot,
  input  logic [WIDTH*10-1:0]       src_reg,
  output logic [WIDTH*2-1:0]        src_renamed,
  output logic [WIDTH*2*SLOT_W-1:0] src_slot,
  input  logic [WIDTH-1:0]          wb_valid,
  input  logic [WIDTH*SLOT_W-1:0]   wb_slot,
  output logic [WIDTH-1:0]          commit_valid,
  output logic [WIDTH*SLOT_W-1:0]   commit_slot,
  output logic [WIDTH-1:0]          commit_we,
  output logic [WIDTH*5-1:0]        commit_rdaddr,
  input  logic                      flush,
  input  logic [SLOT_W-1:0]         flush_slot,
  output logic [SLOT_W:0]           count
);

  rob_entry_t                    ent_q [DEPTH];
  rob_entry_t                    ent_d [DEPTH];
  logic [SLOT_W-1:0]             head_q, head_d, tail_q, tail_d, wptr_q, wptr_d;
  logic [SLOT_W:0]               count_q, count_d, wcnt_q, wcnt_d;
  rob_state_e                    state_q, state_d;

  logic [SLOT_W:0]               n_alloc, n_cmt, free;
  logic                          alloc_fire, chain, rb_we, wb_clash;
  logic [4:0]                    rb_preg;
  logic [SLOT_W-1:0]             fage;
  logic [WIDTH-1:0]              alloc_wr, cmt_clr;
  logic [WIDTH-1:0][4:0]         apreg, cpreg;
  logic [WIDTH-1:0][SLOT_W-1:0]  aslot, cslot, wbs;

  assign apreg         = alloc_preg;
  assign wbs           = wb_slot;
  assign alloc_slot    = aslot;
  assign commit_slot   = cslot;
  assign commit_rdaddr = cpreg;
  assign count         = count_q;

  // Commit is held off during a flush so the walk starts from a stable head.
  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < WIDTH; k++) n_alloc = n_alloc + (SLOT_W+1)'(alloc_req[k]);
    free        = (SLOT_W+1)'(DEPTH) - count_q;
    alloc_ready = (state_q == RUN) && (free >= n_alloc);
    alloc_fire  = alloc_ready && !flush && (n_alloc != '0);
    chain       = (state_q == RUN) && !flush;
    n_cmt       = '0;
    for (int k = 0; k < WIDTH; k++) begin
      aslot[k]        = tail_q + SLOT_W'(k);
      alloc_wr[k]     = alloc_req[k] && alloc_we[k] && (apreg[k] != 5'd0);
      cslot[k]        = head_q + SLOT_W'(k);
      chain           = chain && ent_q[cslot[k]].valid && ent_q[cslot[k]].done;
      commit_valid[k] = chain;
      commit_we[k]    = chain && ent_q[cslot[k]].we;
      cpreg[k]        = ent_q[cslot[k]].preg;
      cmt_clr[k]      = commit_we[k] && (cpreg[k] != 5'd0);
      n_cmt           = n_cmt + (SLOT_W+1)'(chain);
    end
  end

  // flush_slot must name a live entry; everything after it in age order is dropped.
  always_comb begin
    fage    = SLOT_W'(rob_age(AGE_W'(flush_slot), AGE_W'(head_q)));
    ent_d   = ent_q;
    for (int k = 0; k < WIDTH; k++)
      if (commit_valid[k]) ent_d[cslot[k]] = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        if (SLOT_W'(rob_age(AGE_W'(i), AGE_W'(head_q))) > fage) ent_d[i] = '0;
    end
    for (int k = 0; k < WIDTH; k++)
      if (wb_valid[k] && ent_d[wbs[k]].valid) ent_d[wbs[k]].done = 1'b1;
    if (alloc_fire) begin
      for (int k = 0; k < WIDTH; k++)
        if (alloc_req[k]) ent_d[aslot[k]] = '{valid: 1'b1, done: 1'b0,
                                              we: alloc_we[k], preg: apreg[k]};
    end

    head_d  = head_q + n_cmt[SLOT_W-1:0];
    tail_d  = alloc_fire ? tail_q + n_alloc[SLOT_W-1:0] : tail_q;
    count_d = count_q + (alloc_fire ? n_alloc : '0) - n_cmt;
    state_d = state_q;
    wptr_d  = wptr_q;
    wcnt_d  = wcnt_q;
    rb_we   = 1'b0;
    rb_preg = ent_q[wptr_q].preg;
    if (flush) begin
      tail_d  = flush_slot + SLOT_W'(1);
      count_d = (SLOT_W+1)'(fage) + (SLOT_W+1)'(1);
      state_d = REBUILD;
      wptr_d  = head_q;
      wcnt_d  = '0;
    end else if (state_q == REBUILD) begin
      // count is frozen here (no alloc, no commit), so it bounds the walk.
      if (wcnt_q < count_q) begin
        rb_we  = ent_q[wptr_q].we && (ent_q[wptr_q].preg != 5'd0);
        wptr_d = wptr_q + SLOT_W'(1);
        wcnt_d = wcnt_q + (SLOT_W+1)'(1);
      end
      if (wcnt_q + (SLOT_W+1)'(1) >= count_q) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      wcnt_q  <= '0;
      state_q <= RUN;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
      state_q <= state_d;
    end
  end

  riscv_core_rename_table #(.WIDTH(WIDTH), .SLOT_W(SLOT_W)) u_rt (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_reg     (src_reg),
    .src_renamed (src_renamed),
    .src_slot    (src_slot),
    .alloc_fire  (alloc_fire),
    .alloc_wr    (alloc_wr),
    .alloc_preg  (alloc_preg),
    .alloc_slot  (alloc_slot),
    .cmt_clr     (cmt_clr),
    .cmt_preg    (commit_rdaddr),
    .cmt_slot    (commit_slot),
    .clr_all     (flush),
    .rb_we       (rb_we),
    .rb_preg     (rb_preg),
    .rb_slot     (wptr_q)
  );

  always_comb begin
    wb_clash = 1'b0;
    for (int k = 0; k < WIDTH; k++)
      for (int j = 0; j < WIDTH; j++)
        if (wb_valid[k] && alloc_fire && alloc_req[j] && (wbs[k] == aslot[j])) wb_clash = 1'b1;
  end

  a_no_wb_on_alloc: assert property (@(posedge clk) disable iff (!reset_n) !wb_clash);

endmodule

// File: tb/tb_riscv_core_rob_multi.sv
// Directed bench for the reorder buffer at DEPTH=8, WIDTH=2.
module tb_riscv_core_rob_multi;

  localparam int DEPTH = 8, WIDTH = 2, SLOT_W = 3;

  logic        clk, reset_n;
  logic [1:0]  alloc_req, alloc_we;
  logic [9:0]  alloc_preg;
  logic        alloc_ready;
  logic [5:0]  alloc_slot;
  logic [19:0] src_reg;
  logic [3:0]  src_renamed;
  logic [11:0] src_slot;
  logic [1:0]  wb_valid;
  logic [5:0]  wb_slot;
  logic [1:0]  commit_valid, commit_we;
  logic [5:0]  commit_slot;
  logic [9:0]  commit_rdaddr;
  logic        flush;
  logic [2:0]  flush_slot;
  logic [3:0]  count;

  int n_chk = 0, n_fail = 0;

  riscv_core_rob_multi #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SLOT_W(SLOT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_req(alloc_req), .alloc_we(alloc_we), .alloc_preg(alloc_preg),
    .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
    .src_reg(src_reg), .src_renamed(src_renamed), .src_slot(src_slot),
    .wb_valid(wb_valid), .wb_slot(wb_slot),
    .commit_valid(commit_valid), .commit_slot(commit_slot),
    .commit_we(commit_we), .commit_rdaddr(commit_rdaddr),
    .flush(flush), .flush_slot(flush_slot), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = '0; alloc_we = '0; alloc_preg = '0; src_reg = '0;
    wb_valid = '0; wb_slot = '0; flush = 1'b0; flush_slot = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    src_reg = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_src_renamed", 32'(src_renamed), 0);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle();

    // Fill: slots 0/1, 2/3, 4/5, 6/7
    for (int i = 0; i < 4; i++) begin
      alloc_req = 2'b11;
      #1;
      chk("fill_ready", 32'(alloc_ready), 1);
      chk("fill_slot", 32'(alloc_slot), ((2*i+1) << 3) | (2*i));
      tick();
    end
    chk("full_count", 32'(count), 8);
    chk("full_ready2", 32'(alloc_ready), 0);
    alloc_req = 2'b01;
    #1;
    chk("full_ready1", 32'(alloc_ready), 0);
    tick();
    chk("full_count_hold", 32'(count), 8);
    chk("full_tail", 32'(alloc_slot), 8);

    // Writeback slot 1, then slot 0: nothing commits until slot 0 is done
    idle();
    wb_valid = 2'b01; wb_slot = {3'd0, 3'd1};
    tick();
    wb_slot = {3'd0, 3'd0};
    #1;
    chk("wb1_no_commit", 32'(commit_valid), 0);
    tick();
    idle();
    #1;
    chk("wb0_commit_valid", 32'(commit_valid), 3);
    chk("wb0_commit_slot", 32'(commit_slot), 8);
    chk("wb0_commit_we", 32'(commit_we), 0);
    tick();
    chk("after2_count", 32'(count), 6);
    chk("after2_commit", 32'(commit_valid), 0);
    wb_valid = 2'b11; wb_slot = {3'd3, 3'd2};
    tick();
    wb_slot = {3'd5, 3'd4};
    #1;
    chk("drain_slot23", 32'(commit_slot), 26);
    tick();
    wb_slot = {3'd7, 3'd6};
    tick();
    idle();
    tick();
    chk("drain_count", 32'(count), 0);

    // Same-group bypass and commit clear (head = tail = 0)
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b11; alloc_we = 2'b01; alloc_preg = {5'd0, 5'd5};
    src_reg = {5'd7, 5'd5, 5'd0, 5'd5};
    #1;
    chk("byp_renamed", 32'(src_renamed), 4);
    chk("byp_slot", 32'(src_slot[8:6]), 3);
    chk("byp_alloc_slot", 32'(alloc_slot), 35);
    tick();
    idle();
    src_reg = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    chk("tbl_renamed", 32'(src_renamed), 1);
    chk("tbl_slot", 32'(src_slot[2:0]), 3);
    wb_valid = 2'b11; wb_slot = {3'd1, 3'd0};
    tick();
    wb_slot = {3'd3, 3'd2};
    tick();
    wb_valid = 2'b01; wb_slot = {3'd0, 3'd4};
    #1;
    chk("x5_commit_valid", 32'(commit_valid), 3);
    chk("x5_commit_slot", 32'(commit_slot), 26);
    chk("x5_commit_we", 32'(commit_we), 2);
    chk("x5_commit_rd", 32'(commit_rdaddr), 160);
    chk("x5_still_renamed", 32'(src_renamed), 1);
    tick();
    wb_valid = '0;
    #1;
    chk("x5_cleared", 32'(src_renamed), 0);
    chk("stop_at_invalid", 32'(commit_valid), 1);
    tick();
    chk("byp_count", 32'(count), 0);

    // Advance head to 6
    idle();
    alloc_req = 2'b01;
    tick();
    idle();
    wb_valid = 2'b01; wb_slot = {3'd0, 3'd5};
    tick();
    idle();
    tick();
    chk("head6_count", 32'(count), 0);

    // Wrap: 6,7,0,1
    alloc_req = 2'b11;
    #1;
    chk("wrap_slot67", 32'(alloc_slot), 62);
    tick();
    #1;
    chk("wrap_slot01", 32'(alloc_slot), 8);
    chk("wrap_ready", 32'(alloc_ready), 1);
    tick();
    idle();
    chk("wrap_count", 32'(count), 4);
    wb_valid = 2'b11; wb_slot = {3'd7, 3'd6};
    tick();
    wb_slot = {3'd1, 3'd0};
    #1;
    chk("wrap_cv1", 32'(commit_valid), 3);
    chk("wrap_cs1", 32'(commit_slot), 62);
    tick();
    wb_valid = '0;
    #1;
    chk("wrap_cv2", 32'(commit_valid), 3);
    chk("wrap_cs2", 32'(commit_slot), 8);
    tick();
    chk("wrap_count0", 32'(count), 0);

    // Flush with 6 live (head = 2): slots 2:x1 3:x2 4:x3 5:x1 6:x4 7:x2
    alloc_req = 2'b11; alloc_we = 2'b11;
    alloc_preg = {5'd2, 5'd1};
    tick();
    alloc_preg = {5'd1, 5'd3};
    tick();
    alloc_preg = {5'd2, 5'd4};
    tick();
    idle();
    src_reg = {5'd0, 5'd0, 5'd0, 5'd1};
    #1;
    chk("pre_flush_count", 32'(count), 6);
    chk("pre_flush_x1", 32'(src_slot[2:0]), 5);
    flush = 1'b1; flush_slot = 3'd4; alloc_req = 2'b11;
    tick();
    flush = 1'b0; alloc_req = 2'b01; alloc_we = '0; alloc_preg = '0;
    #1;
    chk("flush_count", 32'(count), 3);
    chk("flush_tail", 32'(alloc_slot), 53);
    for (int i = 0; i < 3; i++) begin
      chk("rebuild_ready", 32'(alloc_ready), 0);
      tick();
    end
    chk("run_ready", 32'(alloc_ready), 1);
    alloc_req = '0;
    src_reg = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    chk("rb_renamed", 32'(src_renamed), 7);
    chk("rb_x1", 32'(src_slot[2:0]), 2);
    chk("rb_x2", 32'(src_slot[5:3]), 3);
    chk("rb_x3", 32'(src_slot[8:6]), 4);

    // Reset in the middle of a rebuild walk
    flush = 1'b1; flush_slot = 3'd4;
    tick();
    flush = 1'b0;
    #1;
    chk("mid_rb_ready", 32'(alloc_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_commit", 32'(commit_valid), 0);
    chk("mid_rst_renamed", 32'(src_renamed), 0);
    tick();
    tick();
    reset_n = 1'b1;
    alloc_req = 2'b01;
    #1;
    chk("post_rst_ready", 32'(alloc_ready), 1);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_slot", 32'(alloc_slot), 8);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_rob_multi.md
Name: riscv_core_rob_multi

Overview:
- Parametrised, WIDTH-wide reorder buffer with an integrated rename table; it replaces the fixed 2-wide, 32-entry ROB in the issue stage.
- Allocates up to WIDTH entries per cycle, marks results done on writeback, and commits up to WIDTH entries in order.
- Adds precise squash: on a mispredict the tail rolls back, and the rename table is rebuilt by a walk from head to tail.

Parameters:
- DEPTH, 32: ROB entries; must be a power of 2, at least 4.
- WIDTH, 2: allocate, writeback and commit lanes; range 1..4.
- SLOT_W, clog2(DEPTH): width of a slot index.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_req  in  WIDTH  per-lane allocate request; requesting lanes are contiguous from lane 0.
- alloc_we  in  WIDTH  per-lane "writes a register".
- alloc_preg  in  WIDTH*5  per-lane destination architectural register.
- alloc_ready  out  1  the whole request group fits and the block is not in REBUILD.
- alloc_slot  out  WIDTH*SLOT_W  slot assigned to each lane.
- src_reg  in  WIDTH*10  two source registers per lane.
- src_renamed  out  WIDTH*2  source value is pending in the ROB.
- src_slot  out  WIDTH*2*SLOT_W  producing slot for each source.
- wb_valid  in  WIDTH  writeback strobe.
- wb_slot  in  WIDTH*SLOT_W  slot being marked done.
- commit_valid  out  WIDTH  per-lane commit; set lanes are contiguous from lane 0.
- commit_slot  out  WIDTH*SLOT_W  committed slot.
- commit_we  out  WIDTH  write the register file.
- commit_rdaddr  out  WIDTH*5  register-file write address.
- flush  in  1  mispredict squash.
- flush_slot  in  SLOT_W  slot of the mispredicted branch; it and everything older survive.
- count  out  SLOT_W+1  current occupancy.

Behaviour:
Reset (asynchronous, active-low):
- head = tail = 0, count = 0.
- All valid, done and renamed bits = 0; FSM in RUN.
- Reset outputs: alloc_ready = 1 once reset_n deasserts; commit_valid = 0; src_renamed = 0.
- Assertion mid-operation discards all state immediately.

Allocation:
- n = popcount(alloc_req).
- alloc_ready = (state == RUN) && (DEPTH - count >= n).
- The allocation is all-or-nothing: nothing is written unless alloc_ready = 1.
- Lane k receives slot (tail + k) mod DEPTH; slot indices wrap at DEPTH.
- On the edge: entries are written valid = 1, done = 0; tail advances by n.
- Full (count == DEPTH): alloc_ready = 0 for any n > 0.

Rename lookup (combinational, same cycle):
- Each source is checked against earlier lanes of the same group, youngest match first, and only where that lane has alloc_we = 1 and preg != 0. A match gives renamed = 1 and that lane's slot.
- Otherwise the result comes from the table.
- x0 is never renamed.

Rename update:
- For each allocating lane with we = 1 and preg != 0, the table entry for preg is set to renamed = 1 with that lane's slot.
- The highest lane wins when lanes share a preg.

Writeback:
- Sets done[wb_slot] on the next edge.
- A writeback to an invalid slot is ignored.
- Writeback in the same cycle as that slot's allocation is illegal; it is asserted in simulation.

Commit (combinational outputs; state updates on the edge):
- Lane k commits iff entries head .. head+k are all valid && done.
- Commit stops at the first entry that is not ready.
- On the edge: head advances by the number committed, and committed entries are cleared.
- The register-file writer gives the higher lane priority on equal rdaddr.
- For a committed entry, the table entry for its preg is cleared iff its slot equals the committed slot and no same-cycle allocation renames that preg. Allocation wins.
- count is updated by +allocated − committed in the same edge.
- Commit is disabled in REBUILD.

Flush, RUN → REBUILD:
- Entries younger than flush_slot (age measured from head, modulo DEPTH) are cleared.
- tail = flush_slot + 1.
- The entire rename table is cleared; the walk pointer is set to head.
- Any alloc_req in the flush cycle is dropped.
- Writebacks in the flush cycle are honoured only for slots that survive.
- flush during REBUILD restarts the walk with the new tail.

REBUILD:
- One entry per cycle: if it has we = 1 and preg != 0, the table entry for preg is set to that slot.
- The walk pointer increments.
- When the walk pointer equals tail, the FSM returns to RUN on that edge.
- Writebacks continue during REBUILD.
- Walk duration equals count cycles; with count = 0 the block returns to RUN after 1 cycle.

Decomposition:
- Shared package riscv_core_rob_pkg holds:
  - the entry struct (valid, done, we, preg[4:0]);
  - the FSM state enum (RUN, REBUILD);
  - the function rob_age(slot, head).
- One sub-module, riscv_core_rename_table: the 32-entry renamed/slot array with lookup and bypass, allocate, commit-clear, clear-all and rebuild-write ports.

Test Plan:
- DEPTH = 8, WIDTH = 2, after reset: alloc 2 each cycle for 4 cycles → slots 0/1, 2/3, 4/5, 6/7; then count = 8, alloc_ready = 0, and a 5th request leaves tail = 0.
- Alloc x5 in lane 0 and a source x5 in lane 1 in the same cycle → lane 1 src_renamed = 1 with src_slot = lane 0's slot. Commit of that slot then clears x5 in the table.
- Writeback slots 1 then 0 → no commit after slot 1; both commit in one cycle after slot 0 (commit_valid = 2'b11); head += 2.
- Wrap-around: head = 6, alloc 4 → slots 6, 7, 0, 1; all done → commit 6/7 then 0/1; count returns to 0.
- 6 entries live, flush_slot = head + 2 → tail = head + 3; alloc_ready = 0 for 3 cycles; the table then holds only mappings from the 3 surviving entries.
- Assert reset_n low mid-REBUILD → next cycle count = 0, commit_valid = 0, and alloc_ready = 1 after release.
